// File: rtl/hawk_cmpdcmp_rd_mngr.sv
// HAWK compress/decompress read manager: fetches a source page as single-beat AXI reads
// into the compressor read FIFO, then optionally fetches the zsPage metadata line.
module hawk_cmpdcmp_rd_mngr #(
    parameter int ADDR_W          = 64,
    parameter int DATA_W          = 512,
    parameter int PAGE_LINES      = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmpdcmp_trigger,
    input  logic              comp_decomp,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [6:0]        cpage_lines,
    input  logic              md_rd_en,
    input  logic [ADDR_W-1:0] md_addr,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic              rdfifo_push,
    output logic [DATA_W-1:0] rdfifo_data,
    input  logic              rdfifo_full,
    output logic [DATA_W-1:0] md_data,
    output logic              md_valid,
    output logic              busy,
    output logic              cmpdcmp_rd_done,
    output logic              err_o,
    output logic [2:0]        debug_state
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_DRAIN   = 3'd2;
    localparam logic [2:0] S_MD_ADDR = 3'd3;
    localparam logic [2:0] S_MD_DATA = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [6:0]        PAGE_N     = 7'(PAGE_LINES);
    localparam logic [3:0]        MAX_OS     = 4'(MAX_OUTSTANDING);
    localparam logic [ADDR_W-1:0] LINE_BYTES = ADDR_W'(64);

    logic [2:0]        state_q, state_d;
    logic [6:0]        n_q, n_d, issued_q, issued_d, received_q, received_d;
    logic [3:0]        outst_q, outst_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d, md_addr_q, md_addr_d;
    logic              md_en_q, md_en_d, arvalid_q, arvalid_d;
    logic              md_valid_q, md_valid_d, err_q, err_d;
    logic [DATA_W-1:0] md_data_q, md_data_d;

    logic data_ph, r_beat, ar_hs;

    assign data_ph     = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    // Metadata beat bypasses the FIFO, so only data beats are throttled by it.
    assign rready      = data_ph ? !rdfifo_full : (state_q == S_MD_DATA);
    assign r_beat      = rvalid && rready;
    assign ar_hs       = arvalid_q && arready;
    assign rdfifo_push = data_ph && r_beat;
    assign rdfifo_data = rdata;

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        issued_d   = issued_q;
        received_d = received_q;
        outst_d    = outst_q;
        araddr_d   = araddr_q;
        md_addr_d  = md_addr_q;
        md_en_d    = md_en_q;
        arvalid_d  = arvalid_q;
        md_valid_d = 1'b0;
        md_data_d  = md_data_q;
        err_d      = err_q;

        if (r_beat && ((rresp != 2'b00) || !rlast)) err_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (cmpdcmp_trigger) begin
                    n_d        = comp_decomp ? PAGE_N : cpage_lines;
                    araddr_d   = src_addr;
                    md_en_d    = md_rd_en;
                    md_addr_d  = md_addr;
                    issued_d   = '0;
                    received_d = '0;
                    outst_d    = '0;
                    err_d      = 1'b0;
                    if (!comp_decomp && ((cpage_lines == 7'd0) || (cpage_lines > 7'd64))) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = S_ISSUE;
                    end
                end
            end
            S_ISSUE, S_DRAIN: begin
                issued_d   = issued_q + 7'(ar_hs);
                received_d = received_q + 7'(r_beat);
                outst_d    = outst_q + 4'(ar_hs) - 4'(r_beat);
                if (ar_hs) araddr_d = araddr_q + LINE_BYTES;
                if (state_q == S_ISSUE) begin
                    // A held request stays up: issued is frozen and outstanding only falls.
                    if (issued_d == n_q) begin
                        arvalid_d = 1'b0;
                        state_d   = S_DRAIN;
                    end else begin
                        arvalid_d = (outst_d < MAX_OS);
                    end
                end else if (received_d == n_q) begin
                    if (md_en_q) begin
                        arvalid_d = 1'b1;
                        araddr_d  = md_addr_q;
                        state_d   = S_MD_ADDR;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_MD_ADDR: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    state_d   = S_MD_DATA;
                end
            end
            S_MD_DATA: begin
                if (r_beat) begin
                    md_data_d  = rdata;
                    md_valid_d = 1'b1;
                    state_d    = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            issued_q   <= '0;
            received_q <= '0;
            outst_q    <= '0;
            araddr_q   <= '0;
            md_addr_q  <= '0;
            md_en_q    <= 1'b0;
            arvalid_q  <= 1'b0;
            md_valid_q <= 1'b0;
            md_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            issued_q   <= issued_d;
            received_q <= received_d;
            outst_q    <= outst_d;
            araddr_q   <= araddr_d;
            md_addr_q  <= md_addr_d;
            md_en_q    <= md_en_d;
            arvalid_q  <= arvalid_d;
            md_valid_q <= md_valid_d;
            md_data_q  <= md_data_d;
            err_q      <= err_d;
        end
    end

    assign araddr          = araddr_q;
    assign arlen           = 8'd0;
    assign arvalid         = arvalid_q;
    assign md_data         = md_data_q;
    assign md_valid        = md_valid_q;
    assign busy            = (state_q != S_IDLE);
    assign cmpdcmp_rd_done = (state_q == S_DONE);
    assign err_o           = err_q;
    assign debug_state     = state_q;

endmodule

// File: tb/tb_hawk_cmpdcmp_rd_mngr.sv
// Directed scoreboard bench for hawk_cmpdcmp_rd_mngr with a one-cycle-latency AXI read slave.
module tb_hawk_cmpdcmp_rd_mngr;

    typedef struct {
        logic [63:0] addr;
        logic        md;
    } ar_t;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         cmpdcmp_trigger, comp_decomp, md_rd_en;
    logic [63:0]  src_addr, md_addr, araddr;
    logic [6:0]   cpage_lines;
    logic [7:0]   arlen;
    logic         arvalid, arready, rlast, rvalid, rready;
    logic [511:0] rdata, rdfifo_data, md_data;
    logic [1:0]   rresp;
    logic         rdfifo_push, rdfifo_full, md_valid, busy, cmpdcmp_rd_done, err_o;
    logic [2:0]   debug_state;

    always #5 clk_i = ~clk_i;

    hawk_cmpdcmp_rd_mngr dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .cmpdcmp_trigger(cmpdcmp_trigger),
        .comp_decomp(comp_decomp), .src_addr(src_addr), .cpage_lines(cpage_lines),
        .md_rd_en(md_rd_en), .md_addr(md_addr), .araddr(araddr), .arlen(arlen),
        .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rvalid(rvalid), .rready(rready), .rdfifo_push(rdfifo_push),
        .rdfifo_data(rdfifo_data), .rdfifo_full(rdfifo_full), .md_data(md_data),
        .md_valid(md_valid), .busy(busy), .cmpdcmp_rd_done(cmpdcmp_rd_done),
        .err_o(err_o), .debug_state(debug_state)
    );

    ar_t          exp_ar[$];
    logic [511:0] exp_dat[$];
    ar_t          pend[$];
    int cmp_cnt = 0, fail_cnt = 0;
    int ar_cnt, beat_cnt, max_os, done_cnt, mdv_cnt, stall_seen, dstart, d_mdv, s0;
    int ar_stall, full_cnt;
    logic         prev_stall, err_at_done;
    logic [63:0]  prev_addr, err_addr;

    function automatic logic [511:0] line_data(input logic [63:0] a);
        if (a == 64'h8000) return {64{8'hA5}};
        return {8{a ^ 64'h0123_4567_89AB_CDEF}};
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp_v);
        cmp_cnt++;
        assert (obs === exp_v) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // One clock: slave drives after the edge, monitor/scoreboard samples at the falling edge.
    task automatic tick();
        ar_t e, p;
        int os;
        @(posedge clk_i); #1;
        arready = (ar_stall == 0);
        if (ar_stall > 0) ar_stall--;
        rdfifo_full = (full_cnt > 0);
        if (full_cnt > 0) full_cnt--;
        rlast  = 1'b1;
        rvalid = (pend.size() > 0);
        if (rvalid) begin
            rdata = line_data(pend[0].addr);
            rresp = (!pend[0].md && pend[0].addr == err_addr) ? 2'b10 : 2'b00;
        end else begin
            rdata = '0;
            rresp = 2'b00;
        end
        @(negedge clk_i);
        if (!rst_ni) begin
            exp_ar.delete(); exp_dat.delete(); pend.delete();
            ar_cnt = 0; beat_cnt = 0; prev_stall = 1'b0;
            return;
        end
        if (prev_stall) begin
            chk("ar_hold_valid", arvalid, 1'b1);
            chk("ar_hold_addr", araddr, prev_addr);
            stall_seen++;
        end
        prev_stall = arvalid && !arready;
        prev_addr  = araddr;
        if (exp_dat.size() > 0 && rdfifo_full) chk("rready_when_full", rready, 1'b0);
        if (arvalid && arready) begin
            if (exp_ar.size() == 0) begin
                chk("ar_unexpected", arvalid, 1'b0);
                pend.push_back('{araddr, 1'b0});
            end else begin
                e = exp_ar.pop_front();
                chk("ar_addr", araddr, e.addr);
                pend.push_back('{araddr, e.md});
                if (!e.md) ar_cnt++;
            end
        end
        if (rvalid && rready) begin
            p = pend.pop_front();
            if (p.md) chk("md_no_push", rdfifo_push, 1'b0);
            else begin
                beat_cnt++;
                chk("push_on_beat", rdfifo_push, 1'b1);
                if (exp_dat.size() == 0) chk("push_unexpected", rready, 1'b0);
                else chk("push_data", rdfifo_data, exp_dat.pop_front());
            end
        end else if (rdfifo_push) begin
            chk("push_without_beat", rdfifo_push, 1'b0);
        end
        os = ar_cnt - beat_cnt;
        if (os > max_os) max_os = os;
        if (cmpdcmp_rd_done) begin
            done_cnt++;
            err_at_done = err_o;
        end
        if (md_valid) mdv_cnt++;
    endtask

    task automatic start(input logic comp, input logic [63:0] src, input logic [6:0] cpl,
                         input logic mden, input logic [63:0] mda, input int n);
        for (int i = 0; i < n; i++) begin
            exp_ar.push_back('{src + 64'(64 * i), 1'b0});
            exp_dat.push_back(line_data(src + 64'(64 * i)));
        end
        if (mden) exp_ar.push_back('{mda, 1'b1});
        ar_cnt = 0; beat_cnt = 0; max_os = 0;
        dstart = done_cnt; d_mdv = mdv_cnt; s0 = stall_seen;
        comp_decomp = comp; src_addr = src; cpage_lines = cpl; md_rd_en = mden; md_addr = mda;
        cmpdcmp_trigger = 1'b1;
        tick();
        cmpdcmp_trigger = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && done_cnt == dstart; i++) tick();
        chk({tag, "_done_seen"}, (done_cnt != dstart), 1'b1);
        repeat (3) tick();
        chk({tag, "_done_once"}, done_cnt - dstart, 1);
        chk({tag, "_ar_left"}, exp_ar.size(), 0);
        chk({tag, "_dat_left"}, exp_dat.size(), 0);
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_arvalid"}, arvalid, 1'b0);
        chk({tag, "_araddr"}, araddr, 64'h0);
        chk({tag, "_arlen"}, arlen, 8'h0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_state"}, debug_state, 3'd0);
        chk({tag, "_done"}, cmpdcmp_rd_done, 1'b0);
        chk({tag, "_err"}, err_o, 1'b0);
        chk({tag, "_push"}, rdfifo_push, 1'b0);
        chk({tag, "_md_valid"}, md_valid, 1'b0);
        chk({tag, "_md_data"}, md_data, 512'h0);
    endtask

    initial begin
        rst_ni = 1'b0; cmpdcmp_trigger = 1'b0; comp_decomp = 1'b0; md_rd_en = 1'b0;
        src_addr = '0; md_addr = '0; cpage_lines = '0;
        arready = 1'b1; rvalid = 1'b0; rlast = 1'b1; rdata = '0; rresp = 2'b00;
        rdfifo_full = 1'b0; ar_stall = 0; full_cnt = 0; err_addr = '1;
        ar_cnt = 0; beat_cnt = 0; max_os = 0; done_cnt = 0; mdv_cnt = 0; stall_seen = 0;
        prev_stall = 1'b0; prev_addr = '0; err_at_done = 1'b0;
        repeat (3) tick();
        check_reset_vals("por");
        rst_ni = 1'b1;
        tick();

        // Full compress page, fully ready slave
        start(1'b1, 64'h1000, 7'd0, 1'b0, 64'h0, 64);
        wait_done("cmp", 400);
        chk("cmp_err", err_o, 1'b0);
        chk("cmp_os_limit", (max_os <= 4), 1'b1);
        chk("cmp_ar_total", ar_cnt, 64);

        // Decompress 17 lines plus metadata
        start(1'b0, 64'h20000, 7'd17, 1'b1, 64'h8000, 17);
        wait_done("dcmp_md", 200);
        chk("md_data", md_data, {64{8'hA5}});
        chk("md_valid_pulses", mdv_cnt - d_mdv, 1);
        chk("dcmp_md_err", err_o, 1'b0);

        // FIFO full for 20 cycles mid-page
        start(1'b1, 64'h40000, 7'd0, 1'b0, 64'h0, 64);
        repeat (10) tick();
        full_cnt = 20;
        wait_done("fifo_stall", 400);
        chk("fifo_stall_max_os", max_os, 4);

        // arready stall with request pending
        start(1'b0, 64'h60000, 7'd9, 1'b0, 64'h0, 9);
        repeat (2) tick();
        ar_stall = 5;
        wait_done("ar_stall", 200);
        chk("ar_stall_observed", (stall_seen - s0 >= 4), 1'b1);
        chk("ar_stall_total", ar_cnt, 9);

        // Error response on line 3, then cleared by next trigger
        err_addr = 64'h800C0;
        start(1'b1, 64'h80000, 7'd0, 1'b0, 64'h0, 64);
        wait_done("rresp_err", 400);
        err_addr = '1;
        chk("err_at_done", err_at_done, 1'b1);
        chk("err_sticky", err_o, 1'b1);
        start(1'b0, 64'hA0000, 7'd2, 1'b0, 64'h0, 2);
        chk("err_cleared", err_o, 1'b0);
        wait_done("after_err", 100);

        // Illegal compressed sizes
        start(1'b0, 64'hC0000, 7'd0, 1'b0, 64'h0, 0);
        tick();
        chk("cpl0_fast_done", done_cnt - dstart, 1);
        wait_done("cpl0", 2);
        chk("cpl0_err", err_o, 1'b1);
        chk("cpl0_no_ar", ar_cnt, 0);
        start(1'b0, 64'hC0000, 7'd65, 1'b0, 64'h0, 0);
        wait_done("cpl65", 2);
        chk("cpl65_err", err_o, 1'b1);

        // Reset in the middle of ISSUE
        start(1'b1, 64'hE0000, 7'd0, 1'b0, 64'h0, 64);
        repeat (5) tick();
        chk("pre_reset_busy", busy, 1'b1);
        rst_ni = 1'b0;
        tick();
        check_reset_vals("mid_rst");
        rst_ni = 1'b1;
        tick();

        // Recovery after reset
        start(1'b0, 64'h100000, 7'd3, 1'b1, 64'h8000, 3);
        wait_done("recover", 100);
        chk("recover_md", md_data, {64{8'hA5}});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
